// File: rtl/beta_pkg.sv
// Shared constants and types for the BETA control unit: opcodes, states, instruction classes,
// write-data select encodings and default vectors.
package beta_pkg;

  localparam logic [31:0] ResetVector = 32'h8000_0000;
  localparam logic [31:0] IllopVector = 32'h8000_0004;
  localparam logic [31:0] IrqVector   = 32'h8000_0008;

  localparam logic [5:0] OpLd  = 6'b011000;
  localparam logic [5:0] OpSt  = 6'b011001;
  localparam logic [5:0] OpJmp = 6'b011011;
  localparam logic [5:0] OpBeq = 6'b011100;
  localparam logic [5:0] OpBne = 6'b011101;
  localparam logic [5:0] OpLdr = 6'b011111;

  localparam logic [1:0] WdselPc  = 2'd0;
  localparam logic [1:0] WdselAlu = 2'd1;
  localparam logic [1:0] WdselMem = 2'd2;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLd,
    ClsSt,
    ClsLdr,
    ClsJmp,
    ClsBeq,
    ClsBne,
    ClsIll
  } instr_cls_e;

  // PC+4+(sext(lit)<<2), with the supervisor bit carried over from the current PC.
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] lit);
    logic [31:0] sum;
    sum = pc + 32'd4 + {{14{lit[15]}}, lit, 2'b00};
    return {pc[31], sum[30:0]};
  endfunction

endpackage

// File: rtl/beta_opdecode.sv
// Combinational opcode classifier: IR[31:26] -> instruction class, literal B-operand select,
// legal flag.
module beta_opdecode
  import beta_pkg::*;
(
  input  logic [5:0] opcode,
  output instr_cls_e cls,
  output logic       bsel,
  output logic       legal
);

  always_comb begin
    cls  = ClsIll;
    bsel = 1'b0;
    if (opcode[5]) begin
      // 10xxxx register form, 11xxxx constant form
      cls  = ClsAlu;
      bsel = opcode[4];
    end else begin
      unique case (opcode)
        OpLd:    begin cls = ClsLd;  bsel = 1'b1; end
        OpSt:    begin cls = ClsSt;  bsel = 1'b1; end
        OpLdr:   begin cls = ClsLdr; bsel = 1'b1; end
        OpJmp:   cls = ClsJmp;
        OpBeq:   cls = ClsBeq;
        OpBne:   cls = ClsBne;
        default: cls = ClsIll;
      endcase
    end
  end

  assign legal = (cls != ClsIll);

endmodule

// File: rtl/beta_ctrl.sv
// Multicycle BETA control unit: owns PC/IR, runs the fetch and data-memory handshakes, decodes
// into register-file controls and traps to XP. Define BETA_IRQ_EN to take user-mode interrupts.
module beta_ctrl
  import beta_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = ResetVector,
  parameter logic [31:0] ILLOP_VECTOR = IllopVector,
  parameter logic [31:0] IRQ_VECTOR   = IrqVector
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [4:0]  RA,
  output logic [4:0]  RB,
  output logic [4:0]  RC,
  output logic        RA2SEL,
  output logic        WASEL,
  output logic        WERF,
  input  logic [31:0] RADATA,
  output logic        ASEL,
  output logic        BSEL,
  output logic [5:0]  ALUFN,
  output logic [1:0]  WDSEL,
  output logic [31:0] PC_INC,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  input  logic        DMEM_ACK,
  input  logic        IRQ
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] radata_q, radata_d;
  logic        irq_trap_q, irq_trap_d;

  instr_cls_e  cls;
  logic        lit_bsel;
  logic        legal;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic        irq_take;

  beta_opdecode u_opdecode (
    .opcode (ir_q[31:26]),
    .cls    (cls),
    .bsel   (lit_bsel),
    .legal  (legal)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = branch_target(pc_q, ir_q[15:0]);

`ifdef BETA_IRQ_EN
  logic fetch_entry_q;

  // High only in the first cycle of each FETCH, so a request already raised is never withdrawn.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_entry_q <= 1'b1;
    end else begin
      fetch_entry_q <= (state_q != StFetch);
    end
  end

  assign irq_take = (state_q == StFetch) && fetch_entry_q && IRQ && !pc_q[31];
`else
  logic unused_irq;
  assign unused_irq = IRQ;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    radata_d   = radata_q;
    irq_trap_d = irq_trap_q;
    IMEM_REQ   = 1'b0;
    RA2SEL     = 1'b0;
    WASEL      = 1'b0;
    WERF       = 1'b0;
    ASEL       = 1'b0;
    BSEL       = 1'b0;
    ALUFN      = 6'd0;
    WDSEL      = WdselPc;
    DMEM_REQ   = 1'b0;
    DMEM_WE    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (irq_take) begin
          irq_trap_d = 1'b1;
          state_d    = StWb;
        end else begin
          IMEM_REQ = !RESET;
          if (IMEM_ACK) begin
            ir_d    = IMEM_DATA;
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        radata_d = RADATA;
        unique case (cls)
          ClsAlu:               state_d = StExec;
          ClsLd, ClsSt, ClsLdr: state_d = StMem;
          default:              state_d = StWb;
        endcase
      end
      StExec: state_d = StWb;
      StMem: begin
        DMEM_REQ = 1'b1;
        DMEM_WE  = (cls == ClsSt);
        if (DMEM_ACK) state_d = StWb;
      end
      StWb: begin
        state_d    = StFetch;
        irq_trap_d = 1'b0;
        pc_d       = pc_plus4;
        WERF       = 1'b1;
        if (irq_trap_q) begin
          WASEL = 1'b1;
          pc_d  = IRQ_VECTOR;
        end else if (!legal) begin
          WASEL = 1'b1;
          pc_d  = ILLOP_VECTOR;
        end else begin
          unique case (cls)
            ClsAlu:        WDSEL = WdselAlu;
            ClsLd, ClsLdr: WDSEL = WdselMem;
            ClsSt:         WERF  = 1'b0;
            // JMP may drop the supervisor bit but never raise it.
            ClsJmp:        pc_d = {pc_q[31] & radata_q[31], radata_q[30:2], 2'b00};
            ClsBeq:        if (radata_q == 32'd0) pc_d = br_target;
            ClsBne:        if (radata_q != 32'd0) pc_d = br_target;
            default: ;
          endcase
        end
      end
      default: state_d = StFetch;
    endcase

    if (state_q != StFetch && !irq_trap_q) begin
      BSEL   = lit_bsel;
      ASEL   = (cls == ClsLdr);
      RA2SEL = (cls == ClsSt);
      ALUFN  = (cls == ClsAlu) ? ir_q[31:26] : 6'd0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StFetch;
      pc_q       <= RESET_VECTOR;
      ir_q       <= 32'd0;
      radata_q   <= 32'd0;
      irq_trap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      radata_q   <= radata_d;
      irq_trap_q <= irq_trap_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign RA        = ir_q[20:16];
  assign RB        = ir_q[15:11];
  assign RC        = ir_q[25:21];
  // An interrupt trap links the interrupted PC itself, not PC+4.
  assign PC_INC    = irq_trap_q ? pc_q : pc_plus4;

endmodule

// File: tb/tb_beta_ctrl.sv
// Scoreboard bench for beta_ctrl: expected write-backs and next fetch addresses are queued as
// each instruction is issued and compared when the DUT writes back or fetches.
module tb_beta_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [4:0]  RA, RB, RC;
  logic        RA2SEL, WASEL, WERF;
  logic [31:0] RADATA;
  logic        ASEL, BSEL;
  logic [5:0]  ALUFN;
  logic [1:0]  WDSEL;
  logic [31:0] PC_INC;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic        IRQ;

  beta_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_DATA (IMEM_DATA),
    .RA        (RA),
    .RB        (RB),
    .RC        (RC),
    .RA2SEL    (RA2SEL),
    .WASEL     (WASEL),
    .WERF      (WERF),
    .RADATA    (RADATA),
    .ASEL      (ASEL),
    .BSEL      (BSEL),
    .ALUFN     (ALUFN),
    .WDSEL     (WDSEL),
    .PC_INC    (PC_INC),
    .DMEM_REQ  (DMEM_REQ),
    .DMEM_WE   (DMEM_WE),
    .DMEM_ACK  (DMEM_ACK),
    .IRQ       (IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wasel;
    logic [4:0]  waddr;
    logic [1:0]  wdsel;
    logic [31:0] link;
    logic        bsel_chk;
    logic        bsel;
  } wb_exp_t;

  wb_exp_t     wb_q[$];
  logic [31:0] fetch_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int werf_cnt = 0;
  int dreq_cnt = 0;
  int dwe_cnt  = 0;
  int ra2_low  = 0;
  int asel_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                      input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  task automatic push_wb(input logic wasel, input logic [4:0] waddr, input logic [1:0] wdsel,
                         input logic [31:0] link, input logic bsel_chk, input logic bsel);
    wb_exp_t e;
    e.wasel = wasel; e.waddr = waddr; e.wdsel = wdsel; e.link = link;
    e.bsel_chk = bsel_chk; e.bsel = bsel;
    wb_q.push_back(e);
  endtask

  task automatic monitor();
    wb_exp_t e;
    if (RESET) return;
    if (DMEM_REQ) begin
      dreq_cnt++;
      if (DMEM_WE) dwe_cnt++;
      if (!RA2SEL) ra2_low++;
      if (ASEL) asel_cnt++;
    end
    if (WERF) begin
      werf_cnt++;
      if (wb_q.size() == 0) begin
        check("wb_unexpected", wb_q.size(), 1);
      end else begin
        e = wb_q.pop_front();
        check("wb_wasel", 32'(WASEL), 32'(e.wasel));
        if (!e.wasel) check("wb_rc", 32'(RC), 32'(e.waddr));
        check("wb_wdsel", 32'(WDSEL), 32'(e.wdsel));
        check("wb_link", PC_INC, e.link);
        if (e.bsel_chk) check("wb_bsel", 32'(BSEL), 32'(e.bsel));
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
  endtask

  // Called at a negedge; issues one instruction and returns at the next FETCH.
  task automatic run(input string name, input logic [31:0] instr, input logic [31:0] ra,
                     input int iwait, input int dwait, input int exp_lat);
    int          n;
    int          hold;
    int          dcnt;
    logic [31:0] e;
    RADATA = ra;
    n = 0;
    while (!IMEM_REQ && n < 16) begin tick(); n++; end
    if (!IMEM_REQ) begin
      check({name, "_req"}, 32'(IMEM_REQ), 32'd1);
      return;
    end
    if (fetch_q.size() > 0) begin
      e = fetch_q.pop_front();
      check({name, "_addr"}, IMEM_ADDR, e);
    end
    hold = 0;
    for (int i = 0; i < iwait; i++) begin
      tick();
      if (IMEM_REQ) hold++;
    end
    if (iwait > 0) check({name, "_reqhold"}, hold, iwait);
    IMEM_ACK  = 1'b1;
    IMEM_DATA = instr;
    tick();
    IMEM_ACK  = 1'b0;
    IMEM_DATA = 32'd0;
    n = 0;
    dcnt = 0;
    while (!IMEM_REQ && n < 64) begin
      if (DMEM_REQ) begin
        if (dcnt == dwait) DMEM_ACK = 1'b1;
        dcnt++;
      end
      tick();
      DMEM_ACK = 1'b0;
      n++;
    end
    check({name, "_lat"}, iwait + 1 + n, exp_lat);
  endtask

  task automatic clear_counts();
    dreq_cnt = 0; dwe_cnt = 0; ra2_low = 0; asel_cnt = 0;
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] e;
    int          n;
    int          werf_base;
    RESET = 1'b1; IMEM_ACK = 1'b0; IMEM_DATA = 32'd0; RADATA = 32'd0;
    DMEM_ACK = 1'b0; IRQ = 1'b0;
    tick(); tick();
    check("rst_addr", IMEM_ADDR, 32'h8000_0000);
    check("rst_werf", 32'(WERF), 32'd0);
    check("rst_dreq", 32'(DMEM_REQ), 32'd0);
    check("rst_rc", 32'(RC), 32'd0);
    RESET = 1'b0;
    #1;
    check("rel_req", 32'(IMEM_REQ), 32'd1);

    fetch_q.push_back(32'h8000_0000);
    push_wb(1'b0, 5'd2, 2'd1, 32'h8000_0004, 1'b1, 1'b1);
    fetch_q.push_back(32'h8000_0004);
    run("addc", enc(6'b110000, 5'd2, 5'd1, 16'd5), 32'd0, 0, 0, 4);

    push_wb(1'b0, 5'd4, 2'd0, 32'h8000_0008, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0004);
    run("beq_t", enc(6'b011100, 5'd4, 5'd3, 16'hFFFF), 32'd0, 0, 0, 3);

    push_wb(1'b0, 5'd5, 2'd0, 32'h8000_0008, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0008);
    run("bne_nt", enc(6'b011101, 5'd5, 5'd3, 16'd8), 32'd0, 0, 0, 3);

    push_wb(1'b0, 5'd6, 2'd0, 32'h8000_000C, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0018);
    run("bne_t", enc(6'b011101, 5'd6, 5'd3, 16'd3), 32'd7, 0, 0, 3);

    push_wb(1'b0, 5'd7, 2'd1, 32'h8000_001C, 1'b1, 1'b0);
    fetch_q.push_back(32'h8000_001C);
    run("add", enc(6'b100000, 5'd7, 5'd1, {5'd2, 11'd0}), 32'd0, 2, 0, 6);

    clear_counts();
    werf_base = werf_cnt;
    fetch_q.push_back(32'h8000_0020);
    run("st", enc(6'b011001, 5'd8, 5'd1, 16'd0), 32'd0, 0, 3, 7);
    check("st_dreq_cycles", dreq_cnt, 4);
    check("st_dwe_cycles", dwe_cnt, 4);
    check("st_ra2sel_low", ra2_low, 0);
    check("st_no_werf", werf_cnt - werf_base, 0);

    clear_counts();
    push_wb(1'b0, 5'd9, 2'd2, 32'h8000_0024, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0024);
    run("ld", enc(6'b011000, 5'd9, 5'd1, 16'd4), 32'd0, 0, 1, 5);
    check("ld_dwe", dwe_cnt, 0);
    check("ld_asel", asel_cnt, 0);

    clear_counts();
    push_wb(1'b0, 5'd10, 2'd2, 32'h8000_0028, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0028);
    run("ldr", enc(6'b011111, 5'd10, 5'd31, 16'd2), 32'd0, 0, 0, 4);
    check("ldr_asel", asel_cnt, 1);

    push_wb(1'b1, 5'd30, 2'd0, 32'h8000_002C, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0004);
    run("illop", 32'd0, 32'd0, 0, 0, 3);

    push_wb(1'b0, 5'd11, 2'd0, 32'h8000_0008, 1'b0, 1'b0);
    fetch_q.push_back(32'hFFFF_FFFC);
    run("jmp_top", enc(6'b011011, 5'd11, 5'd5, 16'd0), 32'hFFFF_FFFF, 0, 0, 3);

    push_wb(1'b0, 5'd13, 2'd1, 32'h0000_0000, 1'b1, 1'b1);
    fetch_q.push_back(32'h0000_0000);
    run("addc_wrap", enc(6'b110000, 5'd13, 5'd1, 16'd1), 32'd0, 0, 0, 4);

    push_wb(1'b0, 5'd14, 2'd0, 32'h0000_0004, 1'b0, 1'b0);
    fetch_q.push_back(32'h0000_0100);
    run("jmp_user", enc(6'b011011, 5'd14, 5'd5, 16'd0), 32'h0000_0100, 0, 0, 3);

`ifdef BETA_IRQ_EN
    e = fetch_q.pop_front();
    check("irq_pc", IMEM_ADDR, e);
    IRQ = 1'b1;
    #1;
    check("irq_no_req", 32'(IMEM_REQ), 32'd0);
    push_wb(1'b1, 5'd30, 2'd0, 32'h0000_0100, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0008);
    n = 0;
    while (!IMEM_REQ && n < 8) begin tick(); n++; end
    check("irq_lat", n, 2);
    push_wb(1'b0, 5'd12, 2'd1, 32'h8000_000C, 1'b1, 1'b1);
    fetch_q.push_back(32'h8000_000C);
    run("irq_super", enc(6'b110000, 5'd12, 5'd1, 16'd9), 32'd0, 0, 0, 4);
    cur = 32'h8000_000C;
`else
    IRQ = 1'b1;
    push_wb(1'b0, 5'd12, 2'd1, 32'h0000_0104, 1'b1, 1'b1);
    fetch_q.push_back(32'h0000_0104);
    run("irq_ignored", enc(6'b110000, 5'd12, 5'd1, 16'd9), 32'd0, 0, 0, 4);
    cur = 32'h0000_0104;
`endif
    IRQ = 1'b0;

    push_wb(1'b0, 5'd15, 2'd0, cur + 32'd4, 1'b0, 1'b0);
    fetch_q.push_back(32'h0000_0200);
    run("jmp_200", enc(6'b011011, 5'd15, 5'd5, 16'd0), 32'h0000_0200, 0, 0, 3);

    push_wb(1'b0, 5'd16, 2'd0, 32'h0000_0204, 1'b0, 1'b0);
    fetch_q.push_back(32'h0000_0120);
    run("jmp_nosup", enc(6'b011011, 5'd16, 5'd5, 16'd0), 32'h8000_0123, 0, 0, 3);

    push_wb(1'b1, 5'd30, 2'd0, 32'h0000_0124, 1'b0, 1'b0);
    fetch_q.push_back(32'h8000_0004);
    run("illop_user", enc(6'b011110, 5'd17, 5'd1, 16'd0), 32'd0, 0, 0, 3);

    // LD aborted by reset while its data access is outstanding
    werf_base = werf_cnt;
    e = fetch_q.pop_front();
    check("rst_ld_addr", IMEM_ADDR, e);
    IMEM_ACK  = 1'b1;
    IMEM_DATA = enc(6'b011000, 5'd18, 5'd1, 16'd0);
    tick();
    IMEM_ACK  = 1'b0;
    IMEM_DATA = 32'd0;
    n = 0;
    while (!DMEM_REQ && n < 8) begin tick(); n++; end
    check("rst_ld_dreq", 32'(DMEM_REQ), 32'd1);
    tick(); tick();
    RESET = 1'b1;
    #1;
    check("rst_mid_dreq", 32'(DMEM_REQ), 32'd0);
    check("rst_mid_imem", 32'(IMEM_REQ), 32'd0);
    check("rst_mid_werf", 32'(WERF), 32'd0);
    check("rst_mid_pc", IMEM_ADDR, 32'h8000_0000);
    check("rst_mid_ra", 32'(RA), 32'd0);
    tick(); tick();
    RESET = 1'b0;
    #1;
    check("rst_mid_no_wb", werf_cnt - werf_base, 0);

    fetch_q.push_back(32'h8000_0000);
    push_wb(1'b0, 5'd19, 2'd1, 32'h8000_0004, 1'b1, 1'b1);
    fetch_q.push_back(32'h8000_0004);
    run("addc_post", enc(6'b110000, 5'd19, 5'd2, 16'd1), 32'd0, 0, 0, 4);

    e = fetch_q.pop_front();
    check("final_addr", IMEM_ADDR, e);
    check("sb_wb_empty", wb_q.size(), 0);
    check("sb_fetch_empty", fetch_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion",
             n_checks);
    $fatal(1);
  end

endmodule
